// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and rotate helper for the SHA-256 message schedule.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 512;
  localparam int NUM_WORDS = 64;
  localparam int WIN_WORDS = 16;
  localparam int IDX_W     = 6;

  // lowercase sigma0 / sigma1 rotate and shift amounts
  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Next schedule word: sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
module sha256_w_next
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] r0,
  input  logic [WORD_W-1:0] r1,
  input  logic [WORD_W-1:0] r9,
  input  logic [WORD_W-1:0] r14,
  output logic [WORD_W-1:0] wn
);

  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;

  assign s0 = rotr(r1, S0_R1) ^ rotr(r1, S0_R2) ^ (r1 >> S0_SH);
  assign s1 = rotr(r14, S1_R1) ^ rotr(r14, S1_R2) ^ (r14 >> S1_SH);
  assign wn = s1 + r9 + s0 + r0;

endmodule

// File: rtl/sha256_w_sched.sv
// SHA-256 message schedule: loads a 512-bit block, streams W[0..63] over a valid/ready port.
// Optional SHA256_WSCHED_BACK2BACK_EN lets the next block load on the W[63] handshake.
module sha256_w_sched
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLOCK_W-1:0] blk_data,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [WORD_W-1:0]  w_data,
  output logic [IDX_W-1:0]   w_idx,
  output logic               w_last,
  output state_t             state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never drops and its payload never changes until that transfer completes.

  logic [WORD_W-1:0] r     [WIN_WORDS];
  logic [WORD_W-1:0] blk_w [WIN_WORDS];
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] wn;
  logic              last_idx;
  logic              w_hs;
  logic              blk_hs;

  // W[0] occupies the most significant word of the block
  always_comb begin
    for (int i = 0; i < WIN_WORDS; i++) begin
      blk_w[i] = blk_data[BLOCK_W-1-WORD_W*i -: WORD_W];
    end
  end

  sha256_w_next u_w_next (
    .r0  (r[0]),
    .r1  (r[1]),
    .r9  (r[9]),
    .r14 (r[14]),
    .wn  (wn)
  );

  assign last_idx = (idx == IDX_W'(NUM_WORDS - 1));
  assign w_valid  = (state == RUN);
  assign w_data   = r[0];
  assign w_idx    = idx;
  assign w_last   = w_valid && last_idx;
  assign w_hs     = w_valid && w_ready;
  assign blk_hs   = blk_valid && blk_ready;

`ifdef SHA256_WSCHED_BACK2BACK_EN
  assign blk_ready = (state == IDLE) || ((state == RUN) && last_idx && w_ready);
`else
  assign blk_ready = (state == IDLE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < WIN_WORDS; i++) begin
        r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (blk_hs) begin
            for (int i = 0; i < WIN_WORDS; i++) begin
              r[i] <= blk_w[i];
            end
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (w_hs) begin
            if (last_idx) begin
              idx   <= '0;
              state <= IDLE;
`ifdef SHA256_WSCHED_BACK2BACK_EN
              if (blk_hs) begin
                for (int i = 0; i < WIN_WORDS; i++) begin
                  r[i] <= blk_w[i];
                end
                state <= RUN;
              end
`endif
            end else begin
              for (int i = 0; i < WIN_WORDS - 1; i++) begin
                r[i] <= r[i+1];
              end
              r[WIN_WORDS-1] <= wn;
              idx            <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
